// File: rtl/ex_operand_stage_if.sv
// Interface bundling the decode-side, forwarding-side and ALU-side signals
// of the ID/EX operand stage. The slave modport is the stage itself; the
// master modport is whoever drives decode/forwarding and consumes operands.
interface ex_operand_stage_if #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
);
  // pipeline control
  logic           stall;
  logic           flush;
  // decode-stage fields
  logic           id_valid;
  logic [DW-1:0]  id_rdat1;
  logic [DW-1:0]  id_rdat2;
  logic [RW-1:0]  id_rs;
  logic [RW-1:0]  id_rt;
  logic [RW-1:0]  id_wsel;
  logic           id_regwen;
  logic [15:0]    id_imm;
  logic [4:0]     id_shamt;
  logic [OPW-1:0] id_aluop;
  logic [1:0]     id_alusrc;
  // downstream stages, used for forwarding
  logic           exm_regwen;
  logic [RW-1:0]  exm_wsel;
  logic [DW-1:0]  exm_result;
  logic           mwb_regwen;
  logic [RW-1:0]  mwb_wsel;
  logic [DW-1:0]  mwb_wdat;
  // ALU-facing and EX/MEM-facing outputs
  logic [DW-1:0]  portA;
  logic [DW-1:0]  portB;
  logic [OPW-1:0] ALUOP;
  logic           ex_valid;
  logic           ex_regwen;
  logic [RW-1:0]  ex_wsel;
  logic [DW-1:0]  ex_store_dat;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;

  modport slave (
    input  stall, flush,
    input  id_valid, id_rdat1, id_rdat2, id_rs, id_rt, id_wsel, id_regwen,
    input  id_imm, id_shamt, id_aluop, id_alusrc,
    input  exm_regwen, exm_wsel, exm_result, mwb_regwen, mwb_wsel, mwb_wdat,
    output portA, portB, ALUOP, ex_valid, ex_regwen, ex_wsel, ex_store_dat,
    output fwd_a, fwd_b
  );

  modport master (
    output stall, flush,
    output id_valid, id_rdat1, id_rdat2, id_rs, id_rt, id_wsel, id_regwen,
    output id_imm, id_shamt, id_aluop, id_alusrc,
    output exm_regwen, exm_wsel, exm_result, mwb_regwen, mwb_wsel, mwb_wdat,
    input  portA, portB, ALUOP, ex_valid, ex_regwen, ex_wsel, ex_store_dat,
    input  fwd_a, fwd_b
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline latch with RAW forwarding and ALU operand selection.
// Optional feature macro: EX_FORWARD_EN. When defined, rs/rt are forwarded
// from EX/MEM (priority) and MEM/WB; when undefined the latched register
// data is used directly and fwd_a/fwd_b read 0.
module ex_operand_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input logic               CLK,
  input logic               RST,
  ex_operand_stage_if.slave bus
);

  localparam logic [1:0] FWD_LATCH = 2'd0;
  localparam logic [1:0] FWD_EXM   = 2'd1;
  localparam logic [1:0] FWD_MWB   = 2'd2;

  // latched decode fields
  logic           r_valid;
  logic [DW-1:0]  r_rdat1;
  logic [DW-1:0]  r_rdat2;
  logic [RW-1:0]  r_rs;
  logic [RW-1:0]  r_rt;
  logic [RW-1:0]  r_wsel;
  logic           r_regwen;
  logic [15:0]    r_imm;
  logic [4:0]     r_shamt;
  logic [OPW-1:0] r_aluop;
  logic [1:0]     r_alusrc;

  // forwarding selects and forwarded operand values
  logic [1:0]     w_sel_rs;
  logic [1:0]     w_sel_rt;
  logic [DW-1:0]  w_fa;
  logic [DW-1:0]  w_fb;

  // ID/EX latch: reset/flush load a bubble (flush wins over stall), stall holds
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid  <= 1'b0;
      r_rdat1  <= '0;
      r_rdat2  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_wsel   <= '0;
      r_regwen <= 1'b0;
      r_imm    <= 16'h0000;
      r_shamt  <= 5'd0;
      r_aluop  <= '0;
      r_alusrc <= 2'd0;
    end else if (bus.flush) begin
      r_valid  <= 1'b0;
      r_rdat1  <= '0;
      r_rdat2  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_wsel   <= '0;
      r_regwen <= 1'b0;
      r_imm    <= 16'h0000;
      r_shamt  <= 5'd0;
      r_aluop  <= '0;
      r_alusrc <= 2'd0;
    end else if (!bus.stall) begin
      r_valid  <= bus.id_valid;
      r_rdat1  <= bus.id_rdat1;
      r_rdat2  <= bus.id_rdat2;
      r_rs     <= bus.id_rs;
      r_rt     <= bus.id_rt;
      r_wsel   <= bus.id_wsel;
      r_regwen <= bus.id_regwen;
      r_imm    <= bus.id_imm;
      r_shamt  <= bus.id_shamt;
      r_aluop  <= bus.id_aluop;
      r_alusrc <= bus.id_alusrc;
    end
  end

`ifdef EX_FORWARD_EN
  // hazard detection: EX/MEM beats MEM/WB, register 0 is never forwarded
  always_comb begin
    w_sel_rs = FWD_LATCH;
    w_sel_rt = FWD_LATCH;
    if (bus.exm_regwen && (bus.exm_wsel == r_rs) && (r_rs != '0)) begin
      w_sel_rs = FWD_EXM;
    end else if (bus.mwb_regwen && (bus.mwb_wsel == r_rs) && (r_rs != '0)) begin
      w_sel_rs = FWD_MWB;
    end else begin
      w_sel_rs = FWD_LATCH;
    end
    if (bus.exm_regwen && (bus.exm_wsel == r_rt) && (r_rt != '0)) begin
      w_sel_rt = FWD_EXM;
    end else if (bus.mwb_regwen && (bus.mwb_wsel == r_rt) && (r_rt != '0)) begin
      w_sel_rt = FWD_MWB;
    end else begin
      w_sel_rt = FWD_LATCH;
    end
  end

  // forwarded operand muxes
  always_comb begin
    w_fa = r_rdat1;
    w_fb = r_rdat2;
    case (w_sel_rs)
      FWD_EXM: w_fa = bus.exm_result;
      FWD_MWB: w_fa = bus.mwb_wdat;
      default: w_fa = r_rdat1;
    endcase
    case (w_sel_rt)
      FWD_EXM: w_fb = bus.exm_result;
      FWD_MWB: w_fb = bus.mwb_wdat;
      default: w_fb = r_rdat2;
    endcase
  end
`else
  // without forwarding the stage inputs are intentionally ignored
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.exm_regwen, bus.exm_wsel, bus.exm_result,
                          bus.mwb_regwen, bus.mwb_wsel, bus.mwb_wdat, r_rs, r_rt};

  // operands come straight from the latch
  always_comb begin
    w_sel_rs = FWD_LATCH;
    w_sel_rt = FWD_LATCH;
    w_fa     = r_rdat1;
    w_fb     = r_rdat2;
  end
`endif

  // operand select; shifts take the value from rt and the amount from shamt
  always_comb begin
    bus.portA = w_fa;
    bus.portB = w_fb;
    bus.fwd_a = w_sel_rs;
    bus.fwd_b = w_sel_rt;
    case (r_alusrc)
      2'd0: begin
        bus.portA = w_fa;
        bus.portB = w_fb;
      end
      2'd1: begin
        bus.portA = w_fa;
        bus.portB = {{(DW-16){r_imm[15]}}, r_imm};
      end
      2'd2: begin
        bus.portA = w_fa;
        bus.portB = {{(DW-16){1'b0}}, r_imm};
      end
      2'd3: begin
        bus.portA = w_fb;
        bus.portB = {{(DW-5){1'b0}}, r_shamt};
        bus.fwd_a = w_sel_rt;
      end
      default: begin
        bus.portA = w_fa;
        bus.portB = w_fb;
      end
    endcase
  end

  assign bus.ALUOP        = r_aluop;
  assign bus.ex_valid     = r_valid;
  assign bus.ex_regwen    = r_regwen & r_valid;
  assign bus.ex_wsel      = r_wsel;
  assign bus.ex_store_dat = w_fb;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow EX_FORWARD_EN.
module tb_ex_operand_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  ex_operand_stage_if #(.DW(32), .RW(5), .OPW(4)) bus ();

  ex_operand_stage #(.DW(32), .RW(5), .OPW(4)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.id_valid = 1'b0; bus.id_rdat1 = 32'h0; bus.id_rdat2 = 32'h0;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_wsel = 5'd0; bus.id_regwen = 1'b0;
    bus.id_imm = 16'h0; bus.id_shamt = 5'd0; bus.id_aluop = 4'd0; bus.id_alusrc = 2'd0;
    bus.exm_regwen = 1'b0; bus.exm_wsel = 5'd0; bus.exm_result = 32'h0;
    bus.mwb_regwen = 1'b0; bus.mwb_wsel = 5'd0; bus.mwb_wdat = 32'h0;
  endtask

  task automatic load_instr(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [4:0] wsel, input logic [3:0] op,
                            input logic [1:0] src, input logic [15:0] imm,
                            input logic [4:0] shamt);
    bus.id_valid = 1'b1; bus.id_regwen = 1'b1;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rdat1 = d1; bus.id_rdat2 = d2;
    bus.id_wsel = wsel; bus.id_aluop = op; bus.id_alusrc = src;
    bus.id_imm = imm; bus.id_shamt = shamt;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    RST = 1'b1;
    step();
    step();
    check_value("rst_valid", 32'(bus.ex_valid), 32'h0);
    check_value("rst_regwen", 32'(bus.ex_regwen), 32'h0);
    check_value("rst_aluop", 32'(bus.ALUOP), 32'h0);
    check_value("rst_wsel", 32'(bus.ex_wsel), 32'h0);
    check_value("rst_porta", bus.portA, 32'h0);
    RST = 1'b0;

    // plain ADD, no hazards
    load_instr(5'd3, 5'd4, 32'h10, 32'h20, 5'd7, 4'd2, 2'd0, 16'h0, 5'd0);
    step();
    check_value("add_porta", bus.portA, 32'h10);
    check_value("add_portb", bus.portB, 32'h20);
    check_value("add_fwd_a", 32'(bus.fwd_a), 32'h0);
    check_value("add_fwd_b", 32'(bus.fwd_b), 32'h0);
    check_value("add_valid", 32'(bus.ex_valid), 32'h1);
    check_value("add_regwen", 32'(bus.ex_regwen), 32'h1);
    check_value("add_wsel", 32'(bus.ex_wsel), 32'h7);
    check_value("add_aluop", 32'(bus.ALUOP), 32'h2);
    check_value("add_store", bus.ex_store_dat, 32'h20);

    // double hazard on rs: EX/MEM must win
    load_instr(5'd5, 5'd6, 32'h55, 32'h66, 5'd8, 4'd2, 2'd0, 16'h0, 5'd0);
    bus.exm_regwen = 1'b1; bus.exm_wsel = 5'd5; bus.exm_result = 32'hAAAA;
    bus.mwb_regwen = 1'b1; bus.mwb_wsel = 5'd5; bus.mwb_wdat = 32'hBBBB;
    step();
    check_value("dbl_porta", bus.portA, FWD ? 32'hAAAA : 32'h55);
    check_value("dbl_fwd_a", 32'(bus.fwd_a), FWD ? 32'h1 : 32'h0);
    check_value("dbl_portb", bus.portB, 32'h66);
    check_value("dbl_fwd_b", 32'(bus.fwd_b), 32'h0);
    // drop EX/MEM write: MEM/WB now supplies rs, same cycle
    bus.exm_regwen = 1'b0;
    #1;
    check_value("mwb_porta", bus.portA, FWD ? 32'hBBBB : 32'h55);
    check_value("mwb_fwd_a", 32'(bus.fwd_a), FWD ? 32'h2 : 32'h0);

    // register 0 is never forwarded
    load_instr(5'd0, 5'd6, 32'h99, 32'h66, 5'd8, 4'd2, 2'd0, 16'h0, 5'd0);
    bus.exm_regwen = 1'b1; bus.exm_wsel = 5'd0;
    bus.mwb_regwen = 1'b1; bus.mwb_wsel = 5'd0;
    step();
    check_value("r0_porta", bus.portA, 32'h99);
    check_value("r0_fwd_a", 32'(bus.fwd_a), 32'h0);
    bus.exm_regwen = 1'b0; bus.mwb_regwen = 1'b0;

    // immediates
    load_instr(5'd1, 5'd2, 32'h1234, 32'h5678, 5'd9, 4'd3, 2'd1, 16'hFFFC, 5'd0);
    step();
    check_value("simm_porta", bus.portA, 32'h1234);
    check_value("simm_portb", bus.portB, 32'hFFFFFFFC);
    check_value("simm_store", bus.ex_store_dat, 32'h5678);
    load_instr(5'd1, 5'd2, 32'h1234, 32'h5678, 5'd9, 4'd3, 2'd2, 16'hFFFC, 5'd0);
    step();
    check_value("zimm_portb", bus.portB, 32'h0000FFFC);

    // shift with rt forwarded from MEM/WB
    load_instr(5'd1, 5'd9, 32'h1234, 32'h77, 5'd10, 4'd0, 2'd3, 16'h0, 5'd4);
    bus.mwb_regwen = 1'b1; bus.mwb_wsel = 5'd9; bus.mwb_wdat = 32'h1;
    step();
    check_value("sh_porta", bus.portA, FWD ? 32'h1 : 32'h77);
    check_value("sh_portb", bus.portB, 32'h4);
    check_value("sh_fwd_a", 32'(bus.fwd_a), FWD ? 32'h2 : 32'h0);
    check_value("sh_store", bus.ex_store_dat, FWD ? 32'h1 : 32'h77);
    bus.mwb_regwen = 1'b0;

    // stall holds for two cycles despite new inputs
    load_instr(5'd3, 5'd4, 32'h10, 32'h20, 5'd7, 4'd2, 2'd0, 16'h0, 5'd0);
    step();
    bus.stall = 1'b1;
    load_instr(5'd11, 5'd12, 32'hDEAD, 32'hBEEF, 5'd13, 4'd5, 2'd1, 16'h8000, 5'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_value("stall_porta", bus.portA, 32'h10);
      check_value("stall_portb", bus.portB, 32'h20);
      check_value("stall_wsel", 32'(bus.ex_wsel), 32'h7);
      check_value("stall_aluop", 32'(bus.ALUOP), 32'h2);
    end

    // flush beats stall
    bus.flush = 1'b1;
    step();
    check_value("flush_valid", 32'(bus.ex_valid), 32'h0);
    check_value("flush_regwen", 32'(bus.ex_regwen), 32'h0);
    check_value("flush_aluop", 32'(bus.ALUOP), 32'h0);
    check_value("flush_wsel", 32'(bus.ex_wsel), 32'h0);
    bus.flush = 1'b0; bus.stall = 1'b0;

    // asynchronous reset mid-cycle
    load_instr(5'd3, 5'd4, 32'h10, 32'h20, 5'd7, 4'd6, 2'd0, 16'h0, 5'd0);
    step();
    check_value("pre_rst_valid", 32'(bus.ex_valid), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check_value("arst_valid", 32'(bus.ex_valid), 32'h0);
    check_value("arst_regwen", 32'(bus.ex_regwen), 32'h0);
    check_value("arst_aluop", 32'(bus.ALUOP), 32'h0);
    step();
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
